// File: rtl/instr_stream_loader.sv
// Byte-stream loader for instruction memory: parses a length-prefixed, checksummed frame,
// writes big-endian words to program memory and holds the CPU in reset until a verified load.
module instr_stream_loader #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Start,
    input  logic [7:0]        Byte_In,
    input  logic              Byte_Valid,
    output logic              Byte_Ready,
    output logic [31:0]       W_Ins,
    output logic              WE,
    output logic [ADDR_W-1:0] W_Addr,
    output logic              CPU_RST,
    output logic              Done,
    output logic              Err,
    output logic [ADDR_W:0]   Count
);

    localparam logic [32:0] MaxWords = 33'd1 << ADDR_W;

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StLoad,
        StWrite,
        StChk,
        StDone,
        StErr
    } state_e;

    state_e            state_q;
    logic [31:0]       len_q;
    logic [23:0]       word_q;
    logic [7:0]        acc_q;
    logic [1:0]        idx_q;
    logic [31:0]       w_ins_q;
    logic [ADDR_W-1:0] w_addr_q;
    logic [ADDR_W:0]   count_q;
    logic              cpu_rst_q;
    logic              done_q;
    logic              err_q;

    logic              accept;
    logic [31:0]       len_nxt;
    logic [ADDR_W:0]   count_nxt;

    // Ready and write strobe are pure decodes of the state register, so they change only on edges.
    assign Byte_Ready = (state_q == StLen) || (state_q == StLoad) || (state_q == StChk);
    assign WE         = (state_q == StWrite);
    assign accept     = Byte_Valid && Byte_Ready;
    assign len_nxt    = {len_q[23:0], Byte_In};
    assign count_nxt  = count_q + 1'b1;

    assign W_Ins   = w_ins_q;
    assign W_Addr  = w_addr_q;
    assign Count   = count_q;
    assign CPU_RST = cpu_rst_q;
    assign Done    = done_q;
    assign Err     = err_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= StIdle;
            len_q     <= '0;
            word_q    <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            w_ins_q   <= '0;
            w_addr_q  <= '0;
            count_q   <= '0;
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone, StErr: begin
                    if (Start) begin
                        state_q   <= StLen;
                        len_q     <= '0;
                        acc_q     <= '0;
                        idx_q     <= '0;
                        w_addr_q  <= '0;
                        count_q   <= '0;
                        cpu_rst_q <= 1'b1;
                        done_q    <= 1'b0;
                        err_q     <= 1'b0;
                    end
                end
                StLen: begin
                    if (accept) begin
                        len_q <= len_nxt;
                        idx_q <= idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            if ({1'b0, len_nxt} > MaxWords) begin
                                state_q <= StErr;
                                err_q   <= 1'b1;
                            end else if (len_nxt == '0) begin
                                state_q <= StChk;
                            end else begin
                                state_q <= StLoad;
                            end
                        end
                    end
                end
                StLoad: begin
                    if (accept) begin
                        word_q <= {word_q[15:0], Byte_In};
                        acc_q  <= acc_q + Byte_In;
                        idx_q  <= idx_q + 2'd1;
                        // W_Ins only changes once a full word exists, so memory never sees a partial.
                        if (idx_q == 2'd3) begin
                            w_ins_q <= {word_q, Byte_In};
                            state_q <= StWrite;
                        end
                    end
                end
                StWrite: begin
                    w_addr_q <= w_addr_q + 1'b1;
                    count_q  <= count_nxt;
                    state_q  <= (32'(count_nxt) == len_q) ? StChk : StLoad;
                end
                StChk: begin
                    if (accept) begin
                        if (Byte_In == acc_q) begin
                            state_q   <= StDone;
                            done_q    <= 1'b1;
                            cpu_rst_q <= 1'b0;
                        end else begin
                            state_q <= StErr;
                            err_q   <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_stream_loader.sv
// Randomized self-checking bench for instr_stream_loader against a frame-level reference model.
module tb_instr_stream_loader;

    localparam int ADDR_W = 8;
    localparam int MAX_W  = 1 << ADDR_W;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic [31:0]       w_ins;
    logic              we;
    logic [ADDR_W-1:0] w_addr;
    logic              cpu_rst;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   count;

    int          n_cmp = 0;
    int          n_bad = 0;
    string       cur_tag = "init";
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    instr_stream_loader #(.ADDR_W(ADDR_W)) dut (
        .CLK        (clk),
        .RST        (rst_n),
        .Start      (start),
        .Byte_In    (byte_in),
        .Byte_Valid (byte_valid),
        .Byte_Ready (byte_ready),
        .W_Ins      (w_ins),
        .WE         (we),
        .W_Addr     (w_addr),
        .CPU_RST    (cpu_rst),
        .Done       (done),
        .Err        (err),
        .Count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string what, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL [%s] %s: got 0x%0h, expected 0x%0h", cur_tag, what, got, exp);
        end
    endtask

    // Write monitor: records every strobe and checks the stream is stalled during it.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            wr_addr_q.push_back(32'(w_addr));
            wr_data_q.push_back(w_ins);
            check("ready_during_we", 32'(byte_ready), 32'd0);
        end
    end

    task automatic start_load();
        @(negedge clk);
        byte_valid = 1'b0;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wr_addr_q.delete();
        wr_data_q.delete();
        check("start_done", 32'(done), 32'd0);
        check("start_err", 32'(err), 32'd0);
        check("start_cpu_rst", 32'(cpu_rst), 32'd1);
        check("start_ready", 32'(byte_ready), 32'd1);
        check("start_count", 32'(count), 32'd0);
    endtask

    // Offers one byte with the given valid duty (percent) until it is accepted.
    task automatic send_byte(input logic [7:0] b, input int duty, output bit ok);
        int waited = 0;
        ok = 1'b0;
        while (!ok && waited < 400) begin
            @(negedge clk);
            byte_in    = b;
            byte_valid = (int'($urandom_range(99)) < duty);
            ok         = byte_valid && byte_ready;
            @(posedge clk);
            waited++;
        end
    endtask

    task automatic run_frame(input string tag, input logic [7:0] fr[$], input int duty);
        logic [31:0] n;
        logic [7:0]  sum;
        logic [31:0] word;
        int          nb;
        int          exp_wr;
        bit          exp_done;
        bit          ovf;
        bit          ok;
        cur_tag = tag;
        start_load();
        n   = {fr[0], fr[1], fr[2], fr[3]};
        ovf = (n > 32'(MAX_W));
        sum = 8'd0;
        if (ovf) begin
            nb       = 4;
            exp_wr   = 0;
            exp_done = 1'b0;
        end else begin
            nb     = 4 + 4 * int'(n) + 1;
            exp_wr = int'(n);
            for (int i = 4; i < nb - 1; i++) sum = sum + fr[i];
            exp_done = (fr[nb-1] == sum);
        end
        for (int i = 0; i < nb; i++) begin
            send_byte(fr[i], duty, ok);
            if (!ok) begin
                check("byte_accept_timeout", 32'(i), 32'hFFFF_FFFF);
                return;
            end
        end
        @(negedge clk);
        check("n_writes", 32'(wr_addr_q.size()), 32'(exp_wr));
        for (int k = 0; k < exp_wr && k < wr_addr_q.size(); k++) begin
            word = {fr[4+4*k], fr[5+4*k], fr[6+4*k], fr[7+4*k]};
            check("wr_addr", wr_addr_q[k], 32'(k % MAX_W));
            check("wr_data", wr_data_q[k], word);
        end
        check("done", 32'(done), 32'(exp_done));
        check("err", 32'(err), 32'(!exp_done));
        check("cpu_rst", 32'(cpu_rst), 32'(!exp_done));
        check("count", 32'(count), ovf ? 32'd0 : n);
        check("w_addr", 32'(w_addr), ovf ? 32'd0 : (n % 32'(MAX_W)));
        check("ready_after", 32'(byte_ready), 32'd0);
        check("we_after", 32'(we), 32'd0);
    endtask

    initial begin
        logic [7:0] fr[$];
        logic [7:0] sum;
        int         n;
        int         duty;
        bit         ok;

        rst_n      = 1'b0;
        start      = 1'b0;
        byte_in    = 8'd0;
        byte_valid = 1'b0;
        #12;
        cur_tag = "reset";
        check("cpu_rst", 32'(cpu_rst), 32'd1);
        check("ready", 32'(byte_ready), 32'd0);
        check("we", 32'(we), 32'd0);
        check("done", 32'(done), 32'd0);
        check("err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Nominal frame at full rate, then with a stalling source.
        fr = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
               8'h01, 8'h09, 8'h40, 8'h20, 8'h97};
        run_frame("nominal", fr, 100);
        check("nominal_w0", (wr_data_q.size() > 0) ? wr_data_q[0] : 32'h0, 32'h2008_0005);
        run_frame("stall", fr, 30);

        fr[12] = 8'h96;
        run_frame("bad_chk", fr, 100);

        fr = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_frame("len_zero", fr, 100);
        fr = '{8'h00, 8'h00, 8'h01, 8'h01};
        run_frame("len_ovf", fr, 100);

        fr  = '{8'h00, 8'h00, 8'h01, 8'h00};
        sum = 8'd0;
        for (int i = 0; i < 4 * MAX_W; i++) begin
            fr.push_back(8'($urandom));
            sum = sum + fr[fr.size()-1];
        end
        fr.push_back(sum);
        run_frame("len_max", fr, 100);

        for (int r = 0; r < 8; r++) begin
            n   = int'($urandom_range(1, 9));
            fr  = '{8'h00, 8'h00, 8'h00, 8'(n)};
            sum = 8'd0;
            for (int i = 0; i < 4 * n; i++) begin
                fr.push_back(8'($urandom));
                sum = sum + fr[fr.size()-1];
            end
            if ($urandom_range(2) == 0) sum = sum ^ (8'd1 << $urandom_range(7));
            fr.push_back(sum);
            duty = ($urandom_range(1) == 0) ? 100 : int'($urandom_range(20, 80));
            run_frame($sformatf("rand%0d", r), fr, duty);
        end

        // Asynchronous reset in the middle of a load, then no Start.
        cur_tag = "mid_reset";
        start_load();
        fr = '{8'h00, 8'h00, 8'h00, 8'h03, 8'hAB, 8'hCD};
        for (int i = 0; i < 6; i++) send_byte(fr[i], 100, ok);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("w_ins", w_ins, 32'd0);
        check("we", 32'(we), 32'd0);
        check("w_addr", 32'(w_addr), 32'd0);
        check("count", 32'(count), 32'd0);
        check("ready", 32'(byte_ready), 32'd0);
        check("done", 32'(done), 32'd0);
        check("err", 32'(err), 32'd0);
        check("cpu_rst", 32'(cpu_rst), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        wr_addr_q.delete();
        byte_valid = 1'b1;
        repeat (20) @(negedge clk);
        check("no_writes", 32'(wr_addr_q.size()), 32'd0);
        check("ready_idle", 32'(byte_ready), 32'd0);
        check("cpu_rst_idle", 32'(cpu_rst), 32'd1);
        byte_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
